// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // Number of CALC cycles needed to retire all XLEN operand bits.
  function automatic int iter_count(input int xlen, input int unroll);
    return xlen / unroll;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div_i,
  input  logic [XLEN:0]   hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN:0]   hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          ge;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum     = lo_i[0] ? (hi_i + {1'b0, opnd_i}) : hi_i;
    shifted = {hi_i[XLEN-1:0], lo_i[XLEN-1]};
    diff    = shifted - {1'b0, opnd_i};
    ge      = (shifted >= {1'b0, opnd_i});
    hi_o    = {1'b0, sum[XLEN:1]};
    lo_o    = {sum[0], lo_i[XLEN-1:1]};
    if (div_i) begin
      hi_o = ge ? diff : shifted;
      lo_o = {lo_i[XLEN-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit; define MULDIV_FAST_MUL_EN for a single-cycle multiplier path.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int ITER = iter_count(XLEN, UNROLL);
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  logic [XLEN:0]   hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] result_q;
  logic [2:0]      f3_q;
  logic            neg_q;
  logic [CW-1:0]   cnt_q;

  logic            a_neg, b_neg, sign_d, special;
  logic [XLEN-1:0] op_a, op_b, lo_init, opnd_init, special_res;

  // Operands become magnitudes; the sign is reapplied in FIX.
  always_comb begin
    a_neg = a[XLEN-1] && (funct3 == F3_MULH || funct3 == F3_MULHSU ||
                          funct3 == F3_DIV  || funct3 == F3_REM);
    b_neg = b[XLEN-1] && (funct3 == F3_MULH || funct3 == F3_DIV || funct3 == F3_REM);
    op_a        = a_neg ? -a : a;
    op_b        = b_neg ? -b : b;
    sign_d      = (funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
    lo_init     = funct3[2] ? op_a : op_b;
    opnd_init   = funct3[2] ? op_b : op_a;
    special     = 1'b0;
    special_res = '0;
    if (funct3[2] && b == '0) begin
      special     = 1'b1;
      special_res = funct3[1] ? a : '1;
    end else if ((funct3 == F3_DIV || funct3 == F3_REM) && a == SMIN && b == '1) begin
      special     = 1'b1;
      special_res = funct3[1] ? '0 : SMIN;
    end
  end

  logic [XLEN:0]   hi_c [UNROLL+1];
  logic [XLEN-1:0] lo_c [UNROLL+1];

  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .div_i  (f3_q[2]),
      .hi_i   (hi_c[g]),
      .lo_i   (lo_c[g]),
      .opnd_i (opnd_q),
      .hi_o   (hi_c[g+1]),
      .lo_o   (lo_c[g+1])
    );
  end

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  // The full 2*XLEN product is negated so MULH* borrows correctly from the low half.
  always_comb begin
    prod     = {hi_q[XLEN-1:0], lo_q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];
    fix_res  = rem_fix;
    case (f3_q)
      F3_MUL:                        fix_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               fix_res = quo_fix;
      default:                       fix_res = rem_fix;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    fast_a    = {{XLEN{(funct3 != F3_MULHU) && a[XLEN-1]}}, a};
    fast_b    = {{XLEN{(funct3 == F3_MUL || funct3 == F3_MULH) && b[XLEN-1]}}, b};
    fast_prod = fast_a * fast_b;
    fast_res  = (funct3 == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            f3_q   <= funct3;
            neg_q  <= sign_d;
            hi_q   <= '0;
            lo_q   <= lo_init;
            opnd_q <= opnd_init;
            cnt_q  <= CW'(ITER);
            if (special) begin
              result_q <= special_res;
              state_q  <= S_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!funct3[2]) begin
              result_q <= fast_res;
              state_q  <= S_DONE;
            end
`endif
            else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          hi_q  <= hi_c[UNROLL];
          lo_q  <= lo_c[UNROLL];
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          result_q <= fix_res;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: randomized traffic scored against an arithmetic model, plus directed corner cases.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT   = 1;
  localparam int MUL_LAT64 = 1;
`else
  localparam int MUL_LAT   = 34;
  localparam int MUL_LAT64 = 18;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic [2:0]  funct3 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  logic        d2_in_valid = 1'b0;
  logic        d2_in_ready;
  logic [63:0] d2_a = '0, d2_b = '0;
  logic [2:0]  d2_f3 = '0;
  logic        d2_flush = 1'b0;
  logic        d2_out_valid;
  logic        d2_out_ready = 1'b1;
  logic [63:0] d2_result;
  logic        d2_busy;

  muldiv_unit u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .funct3(funct3), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  muldiv_unit #(.XLEN(64), .UNROLL(4)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready), .a(d2_a), .b(d2_b),
    .funct3(d2_f3), .flush(d2_flush), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .result(d2_result), .busy(d2_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0, n_cmp = 0, n_fail = 0, n_done = 0, last_lat = 0, rdy_mode = 0;
  logic [31:0] last_res = '0;
  logic        ov_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference: plain 64-bit arithmetic plus the RISC-V special-case rules.
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] f3);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (f3)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'(uy); return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: if (y == 0) return '1; else begin p = sx / sy; return p[31:0]; end
      3'd5: if (y == 0) return '1; else begin p = ux / uy; return p[31:0]; end
      3'd6: if (y == 0) return x;  else begin p = sx % sy; return p[31:0]; end
      default: if (y == 0) return x; else begin p = ux % uy; return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y, input logic [2:0] f3);
    if (f3[2] && y == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    if (!f3[2]) return MUL_LAT;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Accept observer: records the model's expectation on each handshake edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      cyc++;
      if (flush) sb_q.delete();
      else if (in_valid && in_ready)
        sb_q.push_back('{exp: model(a, b, funct3), lat: exp_lat(a, b, funct3), acc: cyc});
    end
  end

  // Compare process: every cycle out_valid is high, result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!ov_prev) begin
            last_lat = cyc - sb_q[0].acc + 1;
            check("latency", last_lat, sb_q[0].lat);
          end
          check("result", result, sb_q[0].exp);
          check("in_ready_in_done", in_ready, 0);
          if (out_ready) begin
            last_res = result;
            n_done++;
            void'(sb_q.pop_front());
          end
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] f3);
    int n;
    @(negedge clk);
    a = ia; b = ib; funct3 = f3; in_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) timeout("accept_wait");
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; funct3 = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0 || busy) timeout("drain_wait");
  endtask

  task automatic directed(input string name, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [2:0] f3, input logic [31:0] er, input int el);
    check({name, "_model"}, model(ia, ib, f3), er);
    issue(ia, ib, f3);
    wait_drain(200);
    check({name, "_res"}, last_res, er);
    check({name, "_lat"}, last_lat, el);
  endtask

  task automatic run2(input string name, input logic [63:0] ia, input logic [63:0] ib,
                      input logic [2:0] f3, input logic [63:0] er, input int el);
    int lat;
    @(negedge clk);
    d2_a = ia; d2_b = ib; d2_f3 = f3; d2_in_valid = 1'b1;
    @(posedge clk);
    check({name, "_accept"}, d2_in_ready, 1);
    lat = 1;
    @(negedge clk);
    d2_in_valid = 1'b0;
    while (!d2_out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!d2_out_valid) timeout({name, "_wait"});
    else begin
      check({name, "_res"}, d2_result, er);
      check({name, "_lat"}, lat, el);
    end
    @(negedge clk);
    check({name, "_idle"}, d2_in_ready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation bound expired");
    $fatal(1);
  end

  initial begin
    int n, done_before;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_d2_result", d2_result, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    directed("div_neg",   32'hFFFF_FFF9, 32'd2,         3'd4, 32'hFFFF_FFFD, 34);
    directed("rem_neg",   32'hFFFF_FFF9, 32'd2,         3'd6, 32'hFFFF_FFFF, 34);
    directed("divu_zero", 32'd100,       32'd0,         3'd5, 32'hFFFF_FFFF, 1);
    directed("remu_zero", 32'd100,       32'd0,         3'd7, 32'h0000_0064, 1);
    directed("div_ovf",   32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 32'h8000_0000, 1);
    directed("rem_ovf",   32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 32'h0000_0000, 1);
    directed("mul_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 32'h0000_0001, MUL_LAT);
    directed("mulh_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 32'h0000_0000, MUL_LAT);
    directed("mulhu_ones",32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 32'hFFFF_FFFE, MUL_LAT);
    directed("mulhsu_ones",32'hFFFF_FFFF,32'hFFFF_FFFF, 3'd2, 32'hFFFF_FFFF, MUL_LAT);

    // Backpressure: result held while the consumer stalls.
    rdy_mode = 1;
    @(posedge clk); #2;
    issue(32'd1000, 32'd7, 3'd5);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout("bp_wait");
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_result", result, 32'd142);
    end
    rdy_mode = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_in_ready_after", in_ready, 1);
    directed("bp_next", 32'd5, 32'd3, 3'd0, 32'd15, MUL_LAT);

    // Flush mid-CALC with a competing request.
    issue(32'h1234_5678, 32'd3, 3'd5);
    repeat (9) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; a = 32'd9; b = 32'd9; funct3 = 3'd0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_out_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    done_before = n_done;
    repeat (45) @(negedge clk);
    check("flush_no_result", n_done, done_before);
    check("flush_idle", busy, 0);

    // Asynchronous reset mid-CALC.
    issue(32'h0FFF_FFFF, 32'h11, 3'd4);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    done_before = n_done;
    repeat (40) @(negedge clk);
    check("arst_no_result", n_done, done_before);

    // Randomized traffic with random consumer stalls.
    rdy_mode = 2;
    done_before = n_done;
    for (int i = 0; i < 150; i++) issue(pick(), pick(), 3'($urandom_range(0, 7)));
    wait_drain(400);
    rdy_mode = 0;
    check("random_all_done", n_done, done_before + 150);

    // Wide, unrolled instance.
    run2("d2_divu", 64'h0000_0001_0000_0000, 64'd3, 3'd5, 64'h0000_0000_5555_5555, 18);
    run2("d2_mul",  64'd7, 64'd6, 3'd0, 64'd42, MUL_LAT64);
    run2("d2_mulhu", '1, '1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT64);
    run2("d2_rem",  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, iterative RV32M/RV64M multiply/divide execution unit. Successor to the single-cycle combinational ALU M-path.
- Takes rs1/rs2 operands plus funct3 from the execute stage over a valid/ready handshake. Returns one XLEN result per operation over a second valid/ready handshake.
- Adds the MULH/MULHSU/MULHU high-half products. Trades latency for area via a configurable number of bits retired per cycle.

Parameters:
- XLEN, 32, operand/result width; 32 or 64.
- UNROLL, 1, bits retired per iteration cycle; must divide XLEN; legal values 1, 2, 4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- a  in  XLEN  rs1 value.
- b  in  XLEN  rs2 value.
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- flush  in  1  synchronous abort of any in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  operation result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, all iteration registers 0.
- Accept: an operation is accepted on an edge where in_valid && in_ready. a, b and funct3 are captured on that edge; later input changes are ignored.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE -> DONE on accept when a special case applies:
  - divisor==0 with funct3 4..7;
  - DIV/REM with a == signed-min and b == all-ones.
  - Special-case out_valid rises one cycle after accept.
- IDLE -> CALC on any other accept.
- Operand preparation at accept:
  - Signed ops (MULH, DIV, REM): take |a| and |b|.
  - MULHSU: |a| only; b is treated as unsigned.
  - Record the result sign: XOR of the operand signs for MUL-family and DIV; sign of a for REM.
  - MUL uses the raw operands (the low half is sign-agnostic).
- CALC: runs exactly XLEN/UNROLL cycles, then -> FIX.
  - Multiply: shift-add into a 2*XLEN accumulator, UNROLL multiplier bits per cycle.
  - Divide: restoring radix-2, UNROLL quotient bits per cycle, XLEN+1-bit partial remainder.
- FIX: one cycle, then -> DONE.
  - Negate the magnitude if the recorded sign is set.
  - Select the output: low half for MUL; high half for MULH*; quotient for DIV/DIVU; remainder for REM/REMU.
  - Register the selection into result.
- Normal latency: out_valid rises XLEN/UNROLL + 2 edges after the accept edge (34 for XLEN=32, UNROLL=1).
- Special-case results:
  - DIV/DIVU by 0: all-ones.
  - REM/REMU by 0: a.
  - DIV overflow: signed-min.
  - REM overflow: 0.
- DONE: out_valid=1; result is held stable until out_valid && out_ready, then -> IDLE on that edge. in_ready stays low in DONE, so there is no accept on the same edge as the result handoff.
- flush: from any state -> IDLE on the next edge. out_valid deasserts and the result is discarded. flush has priority over accept and over handoff on the same edge; with flush high, in_valid is ignored.
- Reset asserted mid-operation: immediate return to reset values, with no output pulse.
- Arithmetic: all negation is two's complement in XLEN+1 bits, so |signed-min| does not overflow.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: funct3 0..3 use a combinational 2*XLEN signed/unsigned product registered at accept. State goes IDLE -> DONE and out_valid rises one cycle after accept. Divide is unchanged.
- Undefined: all ops iterate as above; no XLEN*XLEN multiplier is instantiated.

Decomposition:
- Package muldiv_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - funct3 localparams (F3_MUL..F3_REMU);
  - a function computing the iteration count from XLEN and UNROLL.
- Sub-module muldiv_step: one combinational radix-2 iteration (shift-add or restoring-subtract step, selected by a mode input), instantiated UNROLL times in a chain inside the CALC datapath.

Test Plan (XLEN=32, UNROLL=1 unless noted):
- DIV a=0xFFFFFFF9, b=2 -> result 0xFFFFFFFD, out_valid exactly 34 cycles after accept. REM with the same operands -> 0xFFFFFFFF.
- DIVU a=100, b=0 -> 0xFFFFFFFF; REMU -> 0x00000064; both with out_valid one cycle after accept. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0x00000000.
- a=b=0xFFFFFFFF: MUL -> 0x00000001, MULH -> 0x00000000, MULHU -> 0xFFFFFFFE, MULHSU -> 0xFFFFFFFF.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable, in_ready=0. Then out_ready=1 -> in_ready=1 next cycle, and a new accept succeeds.
- flush at cycle 10 of CALC, with in_valid also high -> IDLE next edge, out_valid never rises, that request is not accepted. Repeat with rst pulsed mid-CALC -> all outputs at reset values asynchronously.
- UNROLL=4, XLEN=64: DIVU 0x0000000100000000 / 3 -> 0x0000000055555555, latency 18. With MULDIV_FAST_MUL_EN defined: MUL 7*6 -> 42, latency 1.
